full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Parameterisable-width binary full adder with registered outputs; the 1-bit default is the leaf arithmetic cell under co-simulation test.
- Adds operands x and y plus carry-in cin; produces sum A and carry-out cout.
- Sits between stimulus drivers and result monitors.
- Single clock domain; a valid qualifier marks when a result is meaningful.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal 1..64).
- REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs combinational, out_valid follows in_valid directly.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  x/y/cin are valid this cycle.
- x  input  WIDTH  operand X.
- y  input  WIDTH  operand Y.
- cin  input  1  carry-in into bit 0.
- A  output  WIDTH  sum, (x + y + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- out_valid  output  1  A/cout are valid.

Behaviour:
- Bit cell i: s[i] = x[i] ^ y[i] ^ c[i]; c[i+1] = majority(x[i], y[i], c[i]); c[0] = cin; cout = c[WIDTH].
- Carry chain is an explicit ripple of bit cells; no width extension beyond WIDTH+1 bits.
- Reset, checked on a rising clk edge with rst_n = 0:
  - A = 0, cout = 0, out_valid = 0 (REG_OUT = 1).
  - Reset dominates in_valid in the same cycle.
  - Reset mid-stream discards any result in flight.
- REG_OUT = 1:
  - On a rising edge with in_valid = 1, A/cout capture the sum/carry of the current inputs and out_valid = 1.
  - With in_valid = 0, A/cout hold their previous values and out_valid = 0.
  - Latency is exactly 1 cycle; throughput is 1 result per cycle.
- REG_OUT = 0:
  - A/cout are purely combinational from x/y/cin.
  - out_valid = in_valid & rst_n.
  - Reset state is not held.
- Wrap-around: an all-ones operand plus 1 (via y or cin) gives A = 0, cout = 1.
- Inputs containing X/Z: no requirement on A/cout, but out_valid must follow its rules.
- No internal state besides the output registers and the optional overflow register.

Optional Feature:
- Macro: FULL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = c[WIDTH] ^ c[WIDTH-1], i.e. two's-complement signed overflow.
  - For WIDTH = 1, c[WIDTH-1] is cin.
  - ovf is timed and reset (to 0) identically to cout and holds with it when in_valid = 0.
- Undefined:
  - Port ovf does not exist.
  - No overflow logic is synthesised.

Test Plan:
1. WIDTH=1, REG_OUT=1; after reset release, sweep all 8 combinations of x/y/cin with in_valid=1 one per cycle. Required next-cycle A/cout:
   - 000 -> 0/0
   - 001 -> 1/0
   - 010 -> 1/0
   - 011 -> 0/1
   - 100 -> 1/0
   - 101 -> 0/1
   - 110 -> 0/1
   - 111 -> 1/1
   - out_valid = 1 each cycle.
2. Reset: drive x=1, y=1, cin=1 with in_valid=1, then assert rst_n=0 for one edge. Required: A=0, cout=0, out_valid=0 after that edge. Also hold rst_n=0 while in_valid=1: outputs stay 0.
3. Hold: compute x=1, y=0, cin=0 (A=1), then drop in_valid for 5 cycles with inputs changed to 1/1/1. Required: A stays 1, cout stays 0, out_valid = 0.
4. WIDTH=8: x=8'hFF, y=8'h00, cin=1 -> A=8'h00, cout=1. Then x=8'h5A, y=8'h33, cin=0 -> A=8'h8D, cout=0.
5. FULL_ADDER_OVF_EN, WIDTH=8:
   - x=8'h7F, y=8'h01, cin=0 -> A=8'h80, cout=0, ovf=1.
   - x=8'h80, y=8'h80, cin=0 -> A=8'h00, cout=1, ovf=1.
   - x=8'hFF, y=8'h01 -> ovf=0.
6. REG_OUT=0, WIDTH=1: toggle x 0->1 at fixed y=1, cin=0 with no clock edge. Required: A changes 1->0 and cout 0->1 in the same delta. out_valid equals in_valid while rst_n=1 and is 0 while rst_n=0.

Source files
------------

// File: rtl/full_adder.sv
// rtl/full_adder.sv - parameterisable ripple-carry full adder with optional output registers
//
// Optional build macro: FULL_ADDER_OVF_EN adds the signed-overflow output ovf.
//
// Parameters:
//   WIDTH     operand/sum width in bits (1..64)
//   REG_OUT   1 = registered outputs, 1-cycle latency; 0 = combinational outputs
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   x/y/cin are valid this cycle
//   x, y       operands [WIDTH-1:0]
//   cin        carry into bit 0
//   A          sum, (x + y + cin) mod 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   out_valid  A/cout are valid
//   ovf        two's-complement overflow, c[WIDTH] ^ c[WIDTH-1] (FULL_ADDER_OVF_EN only)

module full_adder #(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] A,
    output logic             cout,
`ifdef FULL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    // c[i] is the carry into bit cell i; c[WIDTH] is the carry out of the top cell.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end

`ifdef FULL_ADDER_OVF_EN
    // For WIDTH = 1 the carry into the sign cell is cin itself.
    logic ovf_comb;
    assign ovf_comb = c[WIDTH] ^ c[WIDTH-1];
`endif

    if (REG_OUT != 0) begin : g_reg
        logic [WIDTH-1:0] a_q;
        logic             cout_q;
        logic             valid_q;
`ifdef FULL_ADDER_OVF_EN
        logic             ovf_q;
`endif

        // Results are captured only on valid cycles; otherwise the last
        // result is held while out_valid drops.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                a_q     <= '0;
                cout_q  <= 1'b0;
                valid_q <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
                ovf_q   <= 1'b0;
`endif
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    a_q    <= s;
                    cout_q <= c[WIDTH];
`ifdef FULL_ADDER_OVF_EN
                    ovf_q  <= ovf_comb;
`endif
                end
            end
        end

        assign A         = a_q;
        assign cout      = cout_q;
        assign out_valid = valid_q;
`ifdef FULL_ADDER_OVF_EN
        assign ovf       = ovf_q;
`endif
    end else begin : g_comb
        assign A         = s;
        assign cout      = c[WIDTH];
        assign out_valid = in_valid & rst_n;
`ifdef FULL_ADDER_OVF_EN
        assign ovf       = ovf_comb;
`endif
    end

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - self-checking bench for full_adder (vector tables, corner sequences, random vs model)

module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=1, registered
    logic       x1, y1, ci1, v1, a1, co1, vo1;
    // WIDTH=8, registered
    logic [7:0] x8, y8, a8;
    logic       ci8, v8, co8, vo8;
    // WIDTH=64, registered
    logic [63:0] x64, y64, a64;
    logic        ci64, v64, co64, vo64;
    // WIDTH=1, combinational
    logic       xc, yc, cic, vc, ac, coc, voc;
`ifdef FULL_ADDER_OVF_EN
    logic       ov1, ov8, ov64, ovc;
`endif

    full_adder #(.WIDTH(1), .REG_OUT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .x(x1), .y(y1), .cin(ci1),
        .A(a1), .cout(co1),
`ifdef FULL_ADDER_OVF_EN
        .ovf(ov1),
`endif
        .out_valid(vo1));

    full_adder #(.WIDTH(8), .REG_OUT(1)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .x(x8), .y(y8), .cin(ci8),
        .A(a8), .cout(co8),
`ifdef FULL_ADDER_OVF_EN
        .ovf(ov8),
`endif
        .out_valid(vo8));

    full_adder #(.WIDTH(64), .REG_OUT(1)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .x(x64), .y(y64), .cin(ci64),
        .A(a64), .cout(co64),
`ifdef FULL_ADDER_OVF_EN
        .ovf(ov64),
`endif
        .out_valid(vo64));

    full_adder #(.WIDTH(1), .REG_OUT(0)) uc (
        .clk(clk), .rst_n(rst_n), .in_valid(vc), .x(xc), .y(yc), .cin(cic),
        .A(ac), .cout(coc),
`ifdef FULL_ADDER_OVF_EN
        .ovf(ovc),
`endif
        .out_valid(voc));

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       cin;
        logic [7:0] a;
        logic       co;
        logic       ov;
    } vec_t;

    typedef struct packed {
        logic [63:0] a;
        logic        co;
        logic        ov;
    } res_t;

    vec_t t1[8];
    vec_t t8[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: plain integer addition in w+1 bits; overflow from the
    // signed-add sign rule (equal operand signs, different result sign).
    function automatic res_t model(input logic [63:0] xa, input logic [63:0] ya,
                                   input logic ci, input int w);
        logic [63:0] mask;
        logic [64:0] full;
        res_t r;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        full = {1'b0, xa & mask} + {1'b0, ya & mask} + {64'd0, ci};
        r.a  = full[63:0] & mask;
        r.co = full[w];
        r.ov = (xa[w-1] == ya[w-1]) && (r.a[w-1] != xa[w-1]);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    res_t e8, e64, ec;

    initial begin
        t1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        t1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1};
        t1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0};
        t1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0};
        t1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
        t1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0};
        t1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b1};
        t1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0};

        t8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        t8[1] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        t8[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        t8[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        t8[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};

        rst_n = 1'b0;
        {x1, y1, ci1, v1} = '0;
        {x8, y8, ci8, v8} = '0;
        {x64, y64, ci64, v64} = '0;
        {xc, yc, cic} = '0;
        vc = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_a1", a1, 0);    chk("rst_co1", co1, 0);   chk("rst_vo1", vo1, 0);
        chk("rst_a8", a8, 0);    chk("rst_co8", co8, 0);   chk("rst_vo8", vo8, 0);
        chk("rst_a64", a64, 0);  chk("rst_vo64", vo64, 0);
        chk("rst_comb_vo", voc, 0);
`ifdef FULL_ADDER_OVF_EN
        chk("rst_ov8", ov8, 0);
`endif
        rst_n = 1'b1;
        #1;
        chk("comb_vo_run", voc, 1);

        // Full truth table, one vector per cycle
        for (int i = 0; i < 8; i++) begin
            x1 = t1[i].x[0]; y1 = t1[i].y[0]; ci1 = t1[i].cin; v1 = 1'b1;
            tick();
            chk($sformatf("tt%0d_a", i), a1, t1[i].a[0]);
            chk($sformatf("tt%0d_co", i), co1, t1[i].co);
            chk($sformatf("tt%0d_vo", i), vo1, 1);
`ifdef FULL_ADDER_OVF_EN
            chk($sformatf("tt%0d_ov", i), ov1, t1[i].ov);
`endif
        end

        // Reset discards the in-flight result and dominates in_valid
        x1 = 1'b1; y1 = 1'b1; ci1 = 1'b1; v1 = 1'b1; rst_n = 1'b0;
        tick();
        chk("rst_mid_a", a1, 0); chk("rst_mid_co", co1, 0); chk("rst_mid_vo", vo1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold_a", a1, 0); chk("rst_hold_co", co1, 0); chk("rst_hold_vo", vo1, 0);
        end
        chk("comb_vo_rst", voc, 0);
        rst_n = 1'b1;

        // Hold while in_valid is low
        x1 = 1'b1; y1 = 1'b0; ci1 = 1'b0; v1 = 1'b1;
        tick();
        chk("hold_load_a", a1, 1); chk("hold_load_vo", vo1, 1);
        x1 = 1'b1; y1 = 1'b1; ci1 = 1'b1; v1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_a", a1, 1); chk("hold_co", co1, 0); chk("hold_vo", vo1, 0);
        end

        // 8-bit corner vectors
        for (int i = 0; i < 5; i++) begin
            x8 = t8[i].x; y8 = t8[i].y; ci8 = t8[i].cin; v8 = 1'b1;
            tick();
            chk($sformatf("w8_%0d_a", i), a8, t8[i].a);
            chk($sformatf("w8_%0d_co", i), co8, t8[i].co);
            chk($sformatf("w8_%0d_vo", i), vo8, 1);
`ifdef FULL_ADDER_OVF_EN
            chk($sformatf("w8_%0d_ov", i), ov8, t8[i].ov);
`endif
        end
        v8 = 1'b0; x8 = 8'h12; y8 = 8'h34;
        tick();
        chk("w8_hold_a", a8, 8'h00); chk("w8_hold_co", co8, 1); chk("w8_hold_vo", vo8, 0);

        // Combinational variant: no clock edge needed
        @(negedge clk);
        yc = 1'b1; cic = 1'b0; xc = 1'b0; vc = 1'b1;
        #1;
        chk("comb_a0", ac, 1); chk("comb_co0", coc, 0); chk("comb_vo", voc, 1);
        xc = 1'b1;
        #1;
        chk("comb_a1", ac, 0); chk("comb_co1", coc, 1);
        vc = 1'b0;
        #1;
        chk("comb_vo_off", voc, 0);

        // Random traffic against the reference model
        e8  = '{a: 64'd0, co: 1'b1, ov: 1'b0};
        e64 = '0;
        for (int n = 0; n < 400; n++) begin
            x8  = 8'($urandom); y8 = 8'($urandom); ci8 = 1'($urandom); v8 = 1'($urandom);
            x64 = {$urandom, $urandom}; y64 = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) x64 = {64{1'b1}};
            ci64 = 1'($urandom); v64 = 1'($urandom);
            xc = 1'($urandom); yc = 1'($urandom); cic = 1'($urandom); vc = 1'($urandom);
            if (v8)  e8  = model({56'd0, x8}, {56'd0, y8}, ci8, 8);
            if (v64) e64 = model(x64, y64, ci64, 64);
            ec = model({63'd0, xc}, {63'd0, yc}, cic, 1);
            #1;
            chk("rnd_comb_a", ac, ec.a[0]); chk("rnd_comb_co", coc, ec.co);
            chk("rnd_comb_vo", voc, vc);
            tick();
            chk("rnd_w8_a", a8, e8.a[7:0]);  chk("rnd_w8_co", co8, e8.co);
            chk("rnd_w8_vo", vo8, v8);
            chk("rnd_w64_a", a64, e64.a);    chk("rnd_w64_co", co64, e64.co);
            chk("rnd_w64_vo", vo64, v64);
`ifdef FULL_ADDER_OVF_EN
            chk("rnd_w8_ov", ov8, e8.ov);    chk("rnd_w64_ov", ov64, e64.ov);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
